// File: rtl/l2_conv_pkg.sv
// Shared types and default geometry for the layer-2 convolution scheduler.
// Counter widths are derived here so the scheduler, counter and bench agree.
package l2_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int DEF_OUT_W    = 12;
  localparam int DEF_OUT_H    = 25;
  localparam int DEF_N_CHAN   = 8;
  localparam int DEF_PIPE_LAT = 3;

  // Bits needed to count 0..bound-1, never narrower than one bit.
  function automatic int cnt_w(input int bound);
    return (bound < 2) ? 1 : $clog2(bound);
  endfunction

  localparam int DEF_COL_W   = cnt_w(DEF_OUT_W);
  localparam int DEF_ROW_W   = cnt_w(DEF_OUT_H);
  localparam int DEF_CHAN_W  = cnt_w(DEF_N_CHAN);
  localparam int DEF_DRAIN_W = cnt_w(DEF_PIPE_LAT);

endpackage

// File: rtl/l2_win_cnt.sv
// Output-window column/row counter: advances on en_i, col wraps into row, clr_i wins.
// Registered counters, line/frame wrap flags decoded combinationally from them.
module l2_win_cnt
  import l2_conv_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int OUT_H = DEF_OUT_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [cnt_w(OUT_W)-1:0]   col_o,
  output logic [cnt_w(OUT_H)-1:0]   row_o,
  output logic                      line_last_o,
  output logic                      frame_last_o
);

  localparam int COL_W = cnt_w(OUT_W);
  localparam int ROW_W = cnt_w(OUT_H);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign line_last_o  = (col_q == COL_W'(OUT_W - 1));
  // Row-level flag only; the full-frame end is line_last_o & frame_last_o.
  assign frame_last_o = (row_q == ROW_W'(OUT_H - 1));
  assign col_o        = col_q;
  assign row_o        = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (line_last_o) begin
        col_d = '0;
        row_d = frame_last_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/l2_conv_sched.sv
// Layer-2 pass sequencer: per channel weight load, OUT_W*OUT_H beats, PIPE_LAT drain.
// Beats only when in_valid_i & out_ready_i; abort/reset return to IDLE at the next edge.
module l2_conv_sched
  import l2_conv_pkg::*;
#(
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_H    = DEF_OUT_H,
  parameter int N_CHAN   = DEF_N_CHAN,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      in_valid_i,
  input  logic                      out_ready_i,
  input  logic                      wack_i,
  output logic                      wreq_o,
  output logic [cnt_w(N_CHAN)-1:0]  wchan_o,
  output logic                      conv_valid_o,
  output logic                      vbit_o,
  output logic [cnt_w(N_CHAN)-1:0]  bias_sel_o,
  output logic [cnt_w(OUT_H)-1:0]   row_o,
  output logic [cnt_w(OUT_W)-1:0]   col_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int CHAN_W  = cnt_w(N_CHAN);
  localparam int DRAIN_W = cnt_w(PIPE_LAT);

  generate
    if (PIPE_LAT < 1) begin : g_bad_pipe_lat
      $error("l2_conv_sched: PIPE_LAT must be at least 1");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;

  logic beat;
  logic win_en, win_clr;
  logic line_last, frame_last;

  assign beat = in_valid_i & out_ready_i;

  l2_win_cnt #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H)
  ) u_win_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (win_clr),
    .en_i         (win_en),
    .col_o        (col_o),
    .row_o        (row_o),
    .line_last_o  (line_last),
    .frame_last_o (frame_last)
  );

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    drain_d      = drain_q;
    win_en       = 1'b0;
    win_clr      = 1'b0;
    wreq_o       = 1'b0;
    conv_valid_o = 1'b0;
    vbit_o       = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_o  = 1'b0;
        win_clr = 1'b1;
        if (start_i) begin
          state_d = ST_WLOAD;
          chan_d  = '0;
          drain_d = '0;
        end
      end
      ST_WLOAD: begin
        wreq_o       = 1'b1;
        conv_valid_o = 1'b1;
        if (wack_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        conv_valid_o = 1'b1;
        vbit_o       = beat;
        win_en       = beat;
        if (beat && line_last && frame_last) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        conv_valid_o = 1'b1;
        drain_d      = drain_q + 1'b1;
        if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
          if (chan_q == CHAN_W'(N_CHAN - 1)) begin
            state_d = ST_DONE;
          end else begin
            chan_d  = chan_q + 1'b1;
            state_d = ST_WLOAD;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
        chan_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        chan_d  = '0;
      end
    endcase

    // Abort overrides every transition, including start in IDLE.
    if (abort_i) begin
      state_d = ST_IDLE;
      chan_d  = '0;
      drain_d = '0;
      win_en  = 1'b0;
      win_clr = 1'b1;
    end
  end

  assign wchan_o    = chan_q;
  assign bias_sel_o = chan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      drain_q <= drain_d;
    end
  end

endmodule

// File: tb/tb_l2_conv_sched.sv
// Scoreboard bench: expected beat/channel sequences queued at start, popped as the DUT emits them.
module tb_l2_conv_sched;
  import l2_conv_pkg::*;

  localparam int CW = DEF_CHAN_W;
  localparam int RW = DEF_ROW_W;
  localparam int KW = DEF_COL_W;

  logic          clk = 1'b0;
  logic          rst, start_i, abort_i, in_valid_i, out_ready_i, wack_i;
  logic          wreq_o, conv_valid_o, vbit_o, busy_o, done_o;
  logic [CW-1:0] wchan_o, bias_sel_o;
  logic [RW-1:0] row_o;
  logic [KW-1:0] col_o;

  always #5 clk = ~clk;

  l2_conv_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .in_valid_i   (in_valid_i),
    .out_ready_i  (out_ready_i),
    .wack_i       (wack_i),
    .wreq_o       (wreq_o),
    .wchan_o      (wchan_o),
    .conv_valid_o (conv_valid_o),
    .vbit_o       (vbit_o),
    .bias_sel_o   (bias_sel_o),
    .row_o        (row_o),
    .col_o        (col_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [CW+RW+KW-1:0] exp_beats[$];
  logic [CW-1:0]       exp_wch[$];

  bit drain_watch, wreq_prev, pass_active;
  bit bp_on, stall_on, noise_on, abort_arm, abort_hit;
  int gap, wreq_cnt, n_done;
  logic [CW-1:0] last_wch;

  task automatic clear_model();
    exp_beats.delete();
    exp_wch.delete();
    drain_watch = 0;
    pass_active = 0;
  endtask

  task automatic push_pass();
    for (int c = 0; c < DEF_N_CHAN; c++) begin
      exp_wch.push_back(CW'(c));
      for (int r = 0; r < DEF_OUT_H; r++)
        for (int k = 0; k < DEF_OUT_W; k++)
          exp_beats.push_back({CW'(c), RW'(r), KW'(k)});
    end
  endtask

  task automatic monitor();
    logic [CW+RW+KW-1:0] e;
    if (vbit_o) begin
      check("vbit_qual", 32'(in_valid_i & out_ready_i), 32'd1);
      if (exp_beats.size() == 0) begin
        check("beat_extra", 32'd1, 32'd0);
      end else begin
        e = exp_beats.pop_front();
        check("beat", 32'({bias_sel_o, row_o, col_o}), 32'(e));
        if (e[RW+KW-1:0] == {RW'(DEF_OUT_H - 1), KW'(DEF_OUT_W - 1)}) begin
          drain_watch = 1;
          gap = 0;
        end
      end
    end else if (drain_watch) begin
      if (wreq_o || done_o) begin
        check("drain_gap", 32'(gap), 32'(DEF_PIPE_LAT));
        drain_watch = 0;
      end else begin
        gap++;
        check("drain_cv", 32'(conv_valid_o), 32'd1);
      end
    end

    if (wreq_o) begin
      if (!wreq_prev) begin
        if (exp_wch.size() == 0) check("wreq_extra", 32'd1, 32'd0);
        else check("wchan", 32'(wchan_o), 32'(exp_wch.pop_front()));
      end
      wreq_cnt++;
      last_wch = wchan_o;
      check("wl_vbit", 32'(vbit_o), 32'd0);
      check("wl_bias", 32'(bias_sel_o), 32'(wchan_o));
    end else begin
      if (wreq_prev && stall_on && last_wch == CW'(3))
        check("stall_hold", 32'(wreq_cnt >= 20), 32'd1);
      wreq_cnt = 0;
    end
    wreq_prev = wreq_o;

    if (done_o) begin
      n_done++;
      check("done_cv", 32'(conv_valid_o), 32'd0);
      pass_active = 0;
    end else if (pass_active) begin
      check("cv_hold", 32'(conv_valid_o), 32'd1);
    end
  endtask

  task automatic step(input bit s = 0, input bit a = 0, input bit r = 0);
    @(posedge clk);
    #1;
    rst         = r;
    start_i     = s;
    abort_i     = a;
    in_valid_i  = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    out_ready_i = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    if (wreq_o) wack_i = (wreq_cnt >= ((stall_on && wchan_o == CW'(3)) ? 20 : 1));
    else        wack_i = noise_on ? 1'($urandom_range(0, 1)) : 1'b0;
    if (abort_arm && bias_sel_o == CW'(5) && row_o == RW'(10) && col_o == KW'(7)) begin
      abort_i   = 1'b1;
      abort_arm = 0;
      abort_hit = 1;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_wreq"},  32'(wreq_o),       32'd0);
    check({tag, "_wchan"}, 32'(wchan_o),      32'd0);
    check({tag, "_cv"},    32'(conv_valid_o), 32'd0);
    check({tag, "_vbit"},  32'(vbit_o),       32'd0);
    check({tag, "_bias"},  32'(bias_sel_o),   32'd0);
    check({tag, "_row"},   32'(row_o),        32'd0);
    check({tag, "_col"},   32'(col_o),        32'd0);
    check({tag, "_busy"},  32'(busy_o),       32'd0);
    check({tag, "_done"},  32'(done_o),       32'd0);
  endtask

  // poke: cycle index at which start_i is pulsed again while the pass is busy (-1 = never)
  task automatic run_pass(input string name, input int poke);
    push_pass();
    n_done = 0;
    step(1);
    pass_active = 1;
    for (int i = 0; i < 12000 && n_done == 0; i++) step(i == poke);
    check({name, "_done_cnt"}, 32'(n_done), 32'd1);
    check({name, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
    check({name, "_wreq_left"}, 32'(exp_wch.size()), 32'd0);
    step();
    check({name, "_post_busy"}, 32'(busy_o), 32'd0);
    check({name, "_post_done"}, 32'(done_o), 32'd0);
    clear_model();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    in_valid_i = 1'b0; out_ready_i = 1'b0; wack_i = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    chk_idle("reset");

    // Full pass at full throughput, with a start pulse while busy.
    run_pass("full", 700);

    bp_on = 1; noise_on = 1;
    run_pass("bp", -1);
    bp_on = 0; noise_on = 0;

    stall_on = 1;
    run_pass("stall", -1);
    stall_on = 0;

    // Abort at channel 5, row 10, col 7.
    push_pass();
    abort_arm = 1; abort_hit = 0; n_done = 0;
    step(1);
    pass_active = 1;
    for (int i = 0; i < 12000 && !abort_hit; i++) step();
    check("abort_hit", 32'(abort_hit), 32'd1);
    clear_model();
    step();
    chk_idle("abort");
    check("abort_no_done", 32'(n_done), 32'd0);

    // Start and abort together in IDLE: abort wins.
    step(1, 1);
    step();
    check("start_abort_busy", 32'(busy_o), 32'd0);

    run_pass("restart", -1);

    // Synchronous reset mid-RUN, with start_i high in the same cycle.
    push_pass();
    n_done = 0;
    step(1);
    pass_active = 1;
    for (int i = 0; i < 150; i++) step();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    step(1, 0, 1);
    clear_model();
    step();
    chk_idle("midrst");
    step();
    check("midrst_stay_idle", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_conv_sched.md
Name: l2_conv_sched

Overview:
Layer-2 convolution scheduler. It sequences one full layer-2 pass over all output channels. For each channel it requests the weight load, then issues OUT_W×OUT_H window beats under input/output flow control, then drains the MAC pipeline. It drives the convolution datapath's valid and beat strobes and the bias-mux select, so the per-channel bias counter downstream stays aligned with the scheduler's own channel index.

Parameters:
OUT_W, 12, output columns per row (beats per line)
OUT_H, 25, output rows per channel
N_CHAN, 8, output channels per layer pass
PIPE_LAT, 3, datapath latency in cycles from last beat to last result written

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  begin layer pass (sampled in IDLE only)
abort_i  in  1  cancel pass, return to IDLE
in_valid_i  in  1  input window data available this cycle
out_ready_i  in  1  output buffer can accept a result
wack_i  in  1  weight loader finished loading requested channel
wreq_o  out  1  weight load request (level, held until wack_i)
wchan_o  out  3  channel whose weights are requested
conv_valid_o  out  1  layer pass active; datapath counters held cleared while low
vbit_o  out  1  window beat strobe
bias_sel_o  out  3  current channel, to the bias mux
row_o  out  5  current output row
col_o  out  4  current output column
busy_o  out  1  not IDLE
done_o  out  1  one-cycle pulse at pass completion

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE, chan/row/col/drain counters 0, all outputs 0.
- States: IDLE, WLOAD, RUN, DRAIN, DONE.
- IDLE: on start_i=1, clear counters and go to WLOAD.
- WLOAD: wreq_o=1, wchan_o=chan. On wack_i=1, go to RUN next cycle; wreq_o drops in that same next cycle. A wack_i arriving in any other state is ignored.
- RUN:
  - beat = in_valid_i & out_ready_i; vbit_o = beat, combinational.
  - On a beat, col increments. At col=OUT_W-1, col wraps to 0 and row increments.
  - A beat at row=OUT_H-1, col=OUT_W-1 clears row/col, loads drain=0 and goes to DRAIN.
  - No beat: all counters hold.
  - Exactly OUT_W×OUT_H beats per channel (300 at defaults).
- DRAIN: vbit_o=0. drain counts up each cycle. When drain=PIPE_LAT-1:
  - if chan=N_CHAN-1, go to DONE;
  - otherwise increment chan and go to WLOAD.
  - DRAIN lasts exactly PIPE_LAT cycles.
  - PIPE_LAT=0 is illegal; assert at elaboration.
- DONE: done_o=1 for exactly one cycle, then IDLE with chan cleared.
- conv_valid_o=1 in WLOAD, RUN and DRAIN. It stays high across channel boundaries so the downstream bias counter is not cleared. It is 0 in IDLE and DONE.
- bias_sel_o = chan, registered. It changes only on the DRAIN→WLOAD transition.
- busy_o=1 in every state except IDLE.
- row_o and col_o reflect the counters before the current beat, i.e. the window being issued this cycle.
- abort_i=1 has priority over every transition. Next state is IDLE, counters clear, no done_o pulse, wreq_o drops the next cycle.
- start_i while busy: ignored.
- start_i and abort_i both high in IDLE: abort wins, stay IDLE.
- rst mid-pass: identical to abort, but takes effect at the same edge.
- Widths: counters are sized $clog2 of their bound, minimum 1. The port widths listed assume the default parameters; ports scale with the parameters.

Decomposition:
- Package l2_conv_pkg: state enum (IDLE, WLOAD, RUN, DRAIN, DONE); default OUT_W/OUT_H/N_CHAN/PIPE_LAT constants; derived counter widths.
- Sub-module l2_win_cnt: col/row counter with en, clr and wrap outputs (line_last, frame_last). Instanced once in l2_conv_sched.

Test Plan:
1. Full pass, defaults, in_valid_i=out_ready_i=1, wack_i one cycle after each wreq_o → exactly 2400 vbit_o pulses (300 per channel); 8 wreq_o with wchan_o=0..7; bias_sel_o steps 0→7; conv_valid_o never drops mid-pass; single done_o pulse.
2. Backpressure: out_ready_i toggles pseudo-randomly at 50% → vbit_o only when both inputs are high; per-channel beat count still 300; row_o/col_o never skip or repeat.
3. Weight-load stall: wack_i delayed 20 cycles for channel 3 → wreq_o held 20+ cycles; vbit_o=0 throughout; conv_valid_o=1; bias_sel_o=3.
4. Drain timing: after the 300th beat of channel 0 → vbit_o=0 for exactly PIPE_LAT=3 cycles, then wreq_o=1 with wchan_o=1.
5. Abort at channel 5, row 10, col 7 → IDLE next cycle; all outputs 0; no done_o. A following start_i restarts at chan 0, row 0, col 0.
6. Synchronous reset asserted mid-RUN, plus start_i while busy → reset clears state at that edge; start_i while busy has no effect on counters or state.
